// File: rtl/load_store_unit.sv
// load_store_unit: MIPS load/store unit (LW, LBU, LHU, SB, SH, SW, LL) fronting a word-wide memory port.
// Latency: accept at cycle N, mem_req from N+1 until acked, wb_valid one cycle after the ack; misaligned/unsupported ops complete at N+1.
// Backpressure: req_ready is high only in IDLE; mem_* are held stable until mem_ack; mem_ack outside ACCESS is ignored.
// Ports: clk, rst_n (sync, active low); req_valid/req_ready, opcode, alu_result, rt_value, rt;
//        mem_req/we/addr/be/wdata, mem_ack, mem_rdata; wb_valid/en/rd/data, misalign_err; link_valid, link_addr.
// Optional: define LL_LINK_EN to track an LL reservation in link_valid/link_addr (tied 0 otherwise).
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_value,
  input  logic [4:0]  rt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        link_valid,
  output logic [29:0] link_addr
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LL  = 6'h30;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_n;
  logic [5:0]  op_q, op_n;
  logic [1:0]  lane_q, lane_n;
  logic [4:0]  rt_q, rt_n;

  logic        req_ready_n, mem_req_n, mem_we_n, wb_valid_n, wb_en_n, misalign_err_n;
  logic [31:0] mem_addr_n, mem_wdata_n, wb_data_n;
  logic [3:0]  mem_be_n;
  logic [4:0]  wb_rd_n;

  // Decode of the incoming request
  logic in_load, in_store, in_mis;
  always_comb begin
    in_load  = (opcode == OP_LW) || (opcode == OP_LBU) || (opcode == OP_LHU) || (opcode == OP_LL);
    in_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    case (opcode)
      OP_LW, OP_SW, OP_LL: in_mis = |alu_result[1:0];
      OP_LHU, OP_SH:       in_mis = alu_result[0];
      default:             in_mis = 1'b0;
    endcase
  end

  // Decode of the latched operation
  logic q_load, q_store;
  assign q_load  = (op_q == OP_LW) || (op_q == OP_LBU) || (op_q == OP_LHU) || (op_q == OP_LL);
  assign q_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  // Zero-extended load data selected from the little-endian lanes
  logic [31:0] load_data;
  always_comb begin
    case (op_q)
      OP_LBU: begin
        case (lane_q)
          2'd0:    load_data = {24'd0, mem_rdata[7:0]};
          2'd1:    load_data = {24'd0, mem_rdata[15:8]};
          2'd2:    load_data = {24'd0, mem_rdata[23:16]};
          default: load_data = {24'd0, mem_rdata[31:24]};
        endcase
      end
      OP_LHU:  load_data = lane_q[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_n        = state;
    op_n           = op_q;
    lane_n         = lane_q;
    rt_n           = rt_q;
    mem_req_n      = mem_req;
    mem_we_n       = mem_we;
    mem_addr_n     = mem_addr;
    mem_be_n       = mem_be;
    mem_wdata_n    = mem_wdata;
    wb_valid_n     = 1'b0;
    wb_en_n        = 1'b0;
    wb_rd_n        = 5'd0;
    wb_data_n      = 32'd0;
    misalign_err_n = 1'b0;
    case (state)
      IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is the handshake
        if (req_valid) begin
          op_n   = opcode;
          lane_n = alu_result[1:0];
          rt_n   = rt;
          if ((in_load || in_store) && !in_mis) begin
            state_n     = ACCESS;
            mem_req_n   = 1'b1;
            mem_we_n    = in_store;
            mem_addr_n  = {alu_result[31:2], 2'b00};
            mem_be_n    = 4'b1111;
            mem_wdata_n = 32'd0;
            case (opcode)
              OP_SB: begin
                mem_be_n    = 4'b0001 << alu_result[1:0];
                mem_wdata_n = {4{rt_value[7:0]}};
              end
              OP_SH: begin
                mem_be_n    = alu_result[1] ? 4'b1100 : 4'b0011;
                mem_wdata_n = {2{rt_value[15:0]}};
              end
              OP_SW:   mem_wdata_n = rt_value;
              default: ;
            endcase
          end else begin
            // Misaligned or unsupported: skip the memory and report straight away
            state_n        = DONE;
            wb_valid_n     = 1'b1;
            misalign_err_n = in_mis;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_n     = DONE;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          mem_addr_n  = 32'd0;
          mem_be_n    = 4'd0;
          mem_wdata_n = 32'd0;
          wb_valid_n  = 1'b1;
          wb_en_n     = q_load;
          wb_rd_n     = q_load ? rt_q : 5'd0;
          wb_data_n   = q_load ? load_data : 32'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    req_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= 6'd0;
      lane_q       <= 2'd0;
      rt_q         <= 5'd0;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      op_q         <= op_n;
      lane_q       <= lane_n;
      rt_q         <= rt_n;
      req_ready    <= req_ready_n;
      mem_req      <= mem_req_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_be       <= mem_be_n;
      mem_wdata    <= mem_wdata_n;
      wb_valid     <= wb_valid_n;
      wb_en        <= wb_en_n;
      wb_rd        <= wb_rd_n;
      wb_data      <= wb_data_n;
      misalign_err <= misalign_err_n;
    end
  end

`ifdef LL_LINK_EN
  // Reservation updates when an access completes; mem_addr still holds the word at the ack
  logic        link_valid_n;
  logic [29:0] link_addr_n;
  always_comb begin
    link_valid_n = link_valid;
    link_addr_n  = link_addr;
    if (state == ACCESS && mem_ack) begin
      if (op_q == OP_LL) begin
        link_valid_n = 1'b1;
        link_addr_n  = mem_addr[31:2];
      end else if (q_store && link_valid && (link_addr == mem_addr[31:2])) begin
        link_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= 30'd0;
    end else begin
      link_valid <= link_valid_n;
      link_addr  <= link_addr_n;
    end
  end
`else
  assign link_valid = 1'b0;
  assign link_addr  = 30'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized check of load_store_unit against a behavioural model.
// Drives and samples 1 time unit after each rising clock edge.
// Memory side is modelled by the bench with a per-operation ack delay.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready;
  logic [5:0]  opcode;
  logic [31:0] alu_result, rt_value;
  logic [4:0]  rt;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_en, misalign_err, link_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [29:0] link_addr;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .alu_result(alu_result), .rt_value(rt_value), .rt(rt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .link_valid(link_valid), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rt;
    logic [31:0] rd;
    int          dly;
    bit          acc;
    bit          we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    bit          wben;
    logic [31:0] wbd;
    bit          mis;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Reservation model (stays clear unless the link feature is built in)
  bit          lm_v = 1'b0;
  logic [29:0] lm_a = 30'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: access size, natural alignment, lane arithmetic
  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [4:0] r, input logic [31:0] rd, input int dly);
    vec_t v;
    int   size;
    int   lane;
    bit   store;
    case (op)
      6'h23, 6'h2B, 6'h30: size = 4;
      6'h25, 6'h29:        size = 2;
      6'h24, 6'h28:        size = 1;
      default:             size = 0;
    endcase
    store   = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    lane    = int'(addr % 4);
    v.op    = op; v.addr = addr; v.wd = wd; v.rt = r; v.rd = rd; v.dly = dly;
    v.acc   = (size != 0) && (addr % size == 0);
    v.mis   = (size != 0) && !v.acc;
    v.maddr = addr - lane;
    v.we    = v.acc && store;
    v.be    = 4'hF;
    v.mwd   = 32'd0;
    v.wben  = v.acc && !store;
    v.wbd   = 32'd0;
    if (v.we) begin
      v.be = 4'(((1 << size) - 1) << lane);
      if (size == 1)      v.mwd = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) v.mwd = (wd & 32'hFFFF) * 32'h00010001;
      else                v.mwd = wd;
    end
    if (v.wben) begin
      if (size == 1)      v.wbd = (rd >> (8 * lane)) & 32'hFF;
      else if (size == 2) v.wbd = (rd >> (8 * lane)) & 32'hFFFF;
      else                v.wbd = rd;
    end
    return v;
  endfunction

  // One complete operation; entered and left 1 unit after a rising edge with the unit idle
  task automatic run(input vec_t v);
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; opcode = v.op; alu_result = v.addr; rt_value = v.wd; rt = v.rt;
    tick();
    req_valid = 1'b0;
    opcode = 6'($urandom); alu_result = $urandom; rt_value = $urandom; rt = 5'($urandom);
    if (v.acc) begin
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, v.we);
      chk("mem_be", mem_be, v.be);
      chk("mem_addr", mem_addr, v.maddr);
      if (v.we) chk("mem_wdata", mem_wdata, v.mwd);
      chk("busy_ready", req_ready, 0);
      for (int i = 0; i < v.dly; i++) begin
        mem_rdata = $urandom;
        tick();
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, v.maddr);
        chk("hold_be", mem_be, v.be);
        chk("early_wb", wb_valid, 0);
      end
      mem_ack = 1'b1; mem_rdata = v.rd;
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk("req_drop", mem_req, 0);
`ifdef LL_LINK_EN
      if (v.op == 6'h30) begin
        lm_v = 1'b1; lm_a = v.addr[31:2];
      end else if (v.we && lm_v && lm_a == v.addr[31:2]) begin
        lm_v = 1'b0;
      end
`endif
    end else begin
      chk("no_mem_req", mem_req, 0);
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_en", wb_en, v.wben);
    chk("wb_data", wb_data, v.wbd);
    chk("misalign_err", misalign_err, v.mis);
    chk("done_ready", req_ready, 0);
    if (v.wben) chk("wb_rd", wb_rd, v.rt);
    chk("link_valid", link_valid, lm_v);
    chk("link_addr", link_addr, lm_a);
    tick();
    chk("wb_one_cycle", wb_valid, 0);
    chk("err_one_cycle", misalign_err, 0);
    chk("back_ready", req_ready, 1);
  endtask

  vec_t tbl[12];
  logic [5:0] ops[8] = '{6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h30, 6'h20};

  initial begin
    // Expected-value table: {op, addr, wd, rt, rd, dly, acc, we, be, maddr, mwd, wben, wbd, mis}
    tbl[0]  = '{6'h23, 32'h100, 32'h0,        5'd5, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0};
    tbl[1]  = '{6'h28, 32'h103, 32'hAB,       5'd0, 32'h0,        0, 1, 1, 4'h8, 32'h100, 32'hABABABAB, 0, 32'h0,        0};
    tbl[2]  = '{6'h25, 32'h202, 32'h0,        5'd7, 32'h8001FFFF, 1, 1, 0, 4'hF, 32'h200, 32'h0,        1, 32'h00008001, 0};
    tbl[3]  = '{6'h24, 32'h201, 32'h0,        5'd8, 32'h8001FFFF, 0, 1, 0, 4'hF, 32'h200, 32'h0,        1, 32'h000000FF, 0};
    tbl[4]  = '{6'h2B, 32'h102, 32'h1234,     5'd3, 32'h0,        0, 0, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0,        1};
    tbl[5]  = '{6'h29, 32'h302, 32'h1234BEEF, 5'd0, 32'h0,        2, 1, 1, 4'hC, 32'h300, 32'hBEEFBEEF, 0, 32'h0,        0};
    tbl[6]  = '{6'h29, 32'h300, 32'h0000CAFE, 5'd0, 32'h0,        0, 1, 1, 4'h3, 32'h300, 32'hCAFECAFE, 0, 32'h0,        0};
    tbl[7]  = '{6'h30, 32'h40,  32'h0,        5'd9, 32'h12345678, 1, 1, 0, 4'hF, 32'h40,  32'h0,        1, 32'h12345678, 0};
    tbl[8]  = '{6'h25, 32'h201, 32'h0,        5'd4, 32'h0,        0, 0, 0, 4'hF, 32'h200, 32'h0,        0, 32'h0,        1};
    tbl[9]  = '{6'h20, 32'h100, 32'h0,        5'd6, 32'h0,        0, 0, 0, 4'hF, 32'h100, 32'h0,        0, 32'h0,        0};
    tbl[10] = '{6'h2B, 32'h104, 32'hA5A50001, 5'd0, 32'h0,        3, 1, 1, 4'hF, 32'h104, 32'hA5A50001, 0, 32'h0,        0};
    tbl[11] = '{6'h24, 32'h203, 32'h0,        5'd1, 32'h7F000000, 0, 1, 0, 4'hF, 32'h200, 32'h0,        1, 32'h0000007F, 0};

    rst_n = 1'b0; req_valid = 1'b0; opcode = 6'd0; alu_result = 32'd0; rt_value = 32'd0;
    rt = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_link_addr", link_addr, 0);
    rst_n = 1'b1;
    tick();

    // A stray ack while idle must not start or finish anything
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_wb", wb_valid, 0);
    chk("stray_ack_ready", req_ready, 1);
    tick();
    chk("stray_ack_wb2", wb_valid, 0);

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // Reservation sequence: LL sets, store to another word keeps, byte store into the word clears
    run(mk(6'h30, 32'h40, 32'h0, 5'd2, 32'h55AA55AA, 0));
`ifdef LL_LINK_EN
    chk("ll_link_valid", link_valid, 1);
    chk("ll_link_addr", link_addr, 30'h10);
`endif
    run(mk(6'h2B, 32'h80, 32'h11223344, 5'd0, 32'h0, 1));
`ifdef LL_LINK_EN
    chk("sw_other_keeps", link_valid, 1);
`endif
    run(mk(6'h28, 32'h43, 32'h77, 5'd0, 32'h0, 0));
    chk("sb_same_clears", link_valid, 0);

    // Randomized operations over a small address window so reservations collide often
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run(mk(op, 32'($urandom_range(0, 63)) | 32'h1000, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(0, 3))));
    end

    // Reset while an ack is withheld: request drops at that edge and nothing is written back
    req_valid = 1'b1; opcode = 6'h23; alu_result = 32'h100; rt = 5'd5;
    tick();
    req_valid = 1'b0;
    chk("rst_seq_req", mem_req, 1);
    tick();
    chk("rst_seq_hold", mem_req, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lm_v = 1'b0; lm_a = 30'd0;
    chk("rst_seq_drop", mem_req, 0);
    chk("rst_seq_ready", req_ready, 1);
    chk("rst_seq_wb", wb_valid, 0);
    chk("rst_seq_link", link_valid, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_seq_no_wb", wb_valid, 0);
      tick();
    end
    run(mk(6'h23, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
